// File: rtl/lenia_pkg.sv
// Shared types and default constants for the Lenia control path.
package lenia_pkg;

    // Generation sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int GEN_W_DEF       = 16;

endpackage

// File: rtl/step_sequencer_edge_sync.sv
// Synchronises an asynchronous level and emits a registered one-cycle
// pulse on each rising edge of it.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchroniser chain, previous-sample flop and registered rise pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the chain and previous sample reset to 1 so that a level
            // held either high or low through reset never looks like a rise;
            // all state here uses non-blocking assignment so every flop
            // samples the pre-edge value of its neighbour.
            sync_q <= '1;
            prev_q <= 1'b1;
            o_rise <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_d};
            prev_q <= sync_q[STAGES-1];
            o_rise <= sync_q[STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Turns slow-clock ticks and single-step requests into start/done
// handshakes with the Lenia core, counting completed generations and
// flagging ticks dropped while a generation is still in flight.
module step_sequencer
    import lenia_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int GEN_W       = GEN_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_slow_clk,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_done,
    input  logic             i_clr_ovr,
    output logic             o_tick,
    output logic             o_start,
    output logic             o_busy,
    output logic [GEN_W-1:0] o_gen,
    output logic             o_overrun
);

    state_t state;
    logic   step_pending;
    logic   trigger;
    logic   run_tick;

    edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_slow_clk),
        .o_rise (o_tick)
    );

    assign run_tick = o_tick & i_run;
    // A tick, a fresh step and a parked step all collapse into one launch.
    assign trigger  = run_tick | i_step | step_pending;
    assign o_busy   = (state != ST_IDLE);

    // Generation FSM with pending-step flag, generation counter and overrun flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            step_pending <= 1'b0;
            o_start      <= 1'b0;
            o_gen        <= '0;
            o_overrun    <= 1'b0;
        end else begin
            o_start <= 1'b0;

            // Park one step request that arrives mid-generation.
            if (state != ST_IDLE && i_step) begin
                step_pending <= 1'b1;
            end

            // A free-run tick while busy is dropped and flagged; set beats clear.
            if (run_tick && state != ST_IDLE) begin
                o_overrun <= 1'b1;
            end else if (i_clr_ovr) begin
                o_overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state        <= ST_START;
                        o_start      <= 1'b1;
                        step_pending <= 1'b0;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_done) begin
                        state <= ST_IDLE;
                        o_gen <= o_gen + GEN_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Consumes the slow toggling clock from the team's clock divider (`Div`) in the `i_clk` domain.
- Turns each rising edge of that clock into a one-cycle tick.
- Uses ticks to launch Lenia generation updates on the core through a start/done handshake.
- Supports free-run, single-step and overrun detection, and keeps a generation counter for the display/debug path.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on i_slow_clk (legal 2..4).
- GEN_W, 16, width of the generation counter.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_slow_clk  input  1  divided clock from the divider stage; treated as asynchronous level.
- i_run  input  1  free-run enable; each tick launches a step while high.
- i_step  input  1  single-step request, 1-cycle pulse, honoured regardless of i_run.
- i_done  input  1  1-cycle pulse from the core: current generation finished.
- i_clr_ovr  input  1  clears o_overrun.
- o_tick  output  1  1-cycle pulse per detected rising edge of i_slow_clk.
- o_start  output  1  1-cycle pulse: core begins a generation.
- o_busy  output  1  high while a generation is in flight (START or WAIT).
- o_gen  output  GEN_W  count of completed generations.
- o_overrun  output  1  sticky: a tick arrived while busy and was dropped.

Behaviour:
- Reset (i_rst high at a clock edge) forces the following:
  - All synchroniser flops and the edge-detect previous sample are set to 1. This prevents a spurious tick whether i_slow_clk is held high or low through reset.
  - FSM goes to IDLE, pending-step flag clears to 0.
  - o_tick=0, o_start=0, o_busy=0, o_gen=0, o_overrun=0.
- Reset mid-operation (START/WAIT) abandons the generation. o_gen does not increment, and a later i_done is ignored because the FSM is in IDLE.
- Edge detect: o_tick is registered and is high exactly one cycle.
  - A rise of i_slow_clk that has settled before edge n gives o_tick high in the cycle after edge n+SYNC_STAGES.
  - Falling edges produce nothing.
- Step request:
  - trigger = (o_tick & i_run) | i_step | step_pending.
  - i_step arriving while busy sets step_pending (depth 1; further i_step pulses while pending are absorbed).
- FSM states: IDLE, START, WAIT.
  - IDLE: if trigger, go to START and clear step_pending. A tick and a step arriving in the same cycle launch ONE generation.
  - START: o_start=1 for this single cycle; unconditionally go to WAIT. i_done in START is ignored.
  - WAIT: on i_done, go to IDLE and increment o_gen in the same edge.
- o_start timing: o_start is high the cycle immediately after the triggering o_tick or i_step cycle.
- o_busy = state != IDLE (registered state decode, no extra latency).
- Overrun: o_tick & i_run while state != IDLE sets o_overrun, and that tick is dropped, not queued.
  - i_clr_ovr clears it.
  - Set and clear in the same cycle: set wins.
- i_done in IDLE: ignored, no count change.
- o_gen wraps from 2^GEN_W-1 to 0 without flag.
- A new generation can start the cycle after returning to IDLE. Minimum period between o_start pulses is 3 cycles (START, WAIT with i_done, IDLE).

Decomposition:
- Shared package lenia_pkg holds:
  - the state enum (IDLE/START/WAIT), 2 bits;
  - default constants for SYNC_STAGES and GEN_W.
- One sub-module, edge_sync, holds the SYNC_STAGES synchroniser, the previous-sample flop and the registered rising-edge pulse. Parameters: STAGES. Ports: i_clk, i_rst, i_d, o_rise. The reset-to-1 rule lives there.
- FSM, pending flag, counter and overrun flag stay in step_sequencer.

Test Plan:
- Hold i_slow_clk=1 through reset, release, keep high 20 cycles -> o_tick never asserts; drop then raise -> exactly one o_tick, SYNC_STAGES+1 cycles after the rise.
- i_run=1, i_slow_clk toggling every 10 cycles, core model returns i_done 4 cycles after o_start -> one o_start per rising edge, each exactly 1 cycle after o_tick; o_gen reaches 5 after 5 edges; o_overrun stays 0.
- i_run=1, core takes 30 cycles (longer than one slow period of 20 cycles) -> a tick during WAIT sets o_overrun and produces no o_start; i_clr_ovr pulse clears it; set and clear in the same cycle leaves it 1.
- i_run=0: pulse i_step in IDLE -> o_start next cycle. Pulse i_step twice during WAIT -> exactly one extra o_start, issued the cycle after return to IDLE.
- o_tick with i_run=1 and i_step in the same cycle in IDLE -> single o_start and o_gen +1 only. Spurious i_done in IDLE -> o_gen unchanged.
- GEN_W=4: run 17 generations -> o_gen goes 15 -> 0 -> 1. Assert i_rst during WAIT, then pulse i_done -> o_gen=0, o_busy=0, no o_start.
